// File: rtl/obstacle_spawner.sv
`timescale 1ns/1ps
// Obstacle slots, spawn spacing, scrolling and BCD score. State advances on i_tick and holds while i_over.
// Outputs are registered one clk after the tick edge; no backpressure. OBST_HISCORE_EN adds a best-score register.
module obstacle_spawner #(
   parameter int          SLOTS        = 3,
   parameter int          COL_W        = 10,
   parameter int          SPAWN_COL    = 700,
   parameter int          NOTHING_EQUI = 53,
   parameter int          PX_PER_POINT = 21,
   parameter int          SCORE_DIGITS = 4,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_tick,
   input  logic                          i_over,
   input  logic [2:0]                    i_speed,
   input  logic [COL_W-1:0]              i_min_empty,
   output logic [SLOTS*(5+COL_W)-1:0]    o_obstacles,
   output logic                          o_spawn,
   output logic [3:0]                    o_active_cnt,
   output logic [4*SCORE_DIGITS-1:0]     o_score,
   output logic [4*SCORE_DIGITS-1:0]     o_hiscore
);

   localparam int                    SW          = 5 + COL_W;
   localparam int                    IDX_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int                    PX_W        = $clog2(PX_PER_POINT + 8);
   localparam logic [COL_W-1:0]      L_SPAWN_COL = COL_W'(SPAWN_COL);
   localparam logic [COL_W-1:0]      L_NEQ       = COL_W'(NOTHING_EQUI);
   localparam logic [PX_W-1:0]       L_PPP       = PX_W'(PX_PER_POINT);
   localparam logic [4*SCORE_DIGITS-1:0] L_SCORE_MAX = {SCORE_DIGITS{4'h9}};

   logic [15:0]             r_lfsr;
   logic                    r_en   [SLOTS];
   logic [3:0]              r_type [SLOTS];
   logic [COL_W-1:0]        r_col  [SLOTS];
   logic [COL_W-1:0]        r_empty;
   logic [PX_W-1:0]         r_px;
   logic [4*SCORE_DIGITS-1:0] r_score;
   logic                    r_spawn;
   logic [3:0]              r_active;

   logic                    w_adv;
   logic [2:0]              w_spd;
   logic [COL_W-1:0]        w_s_col;
   logic [3:0]              w_type;
   logic                    w_full;
   logic [IDX_W-1:0]        w_free_idx;
   logic                    w_load;
   logic [COL_W:0]          w_empty_sum;
   logic [COL_W-1:0]        w_empty_n;
   logic [PX_W-1:0]         w_px_sum;
   logic [4*SCORE_DIGITS-1:0] w_score_inc;
   logic                    w_en_n   [SLOTS];
   logic [3:0]              w_type_n [SLOTS];
   logic [COL_W-1:0]        w_col_n  [SLOTS];
   logic [3:0]              w_cnt_n;

   assign w_adv   = i_tick && !i_over;
   assign w_spd   = (i_speed == 3'd0) ? 3'd1 : i_speed;
   assign w_s_col = COL_W'(w_spd);

   // Upper nibble of the draw byte selects the obstacle; 0..5 and 15 are Nothing.
   always_comb begin
      w_type = 4'd0;
      case (r_lfsr[7:4])
         4'd6:  w_type = 4'd1;
         4'd7:  w_type = 4'd2;
         4'd8:  w_type = 4'd3;
         4'd9:  w_type = 4'd5;
         4'd10: w_type = 4'd6;
         4'd11: w_type = 4'd7;
         4'd12: w_type = 4'd9;
         4'd13: w_type = 4'd10;
         4'd14: w_type = 4'd11;
         default: w_type = 4'd0;
      endcase
   end

   always_comb begin
      w_full     = 1'b1;
      w_free_idx = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!r_en[i]) begin
            w_full     = 1'b0;
            w_free_idx = IDX_W'(i);
         end
      end
   end

   assign w_load = w_adv && !w_full && !(r_empty < i_min_empty) && (w_type != 4'd0);

   always_comb begin
      w_empty_sum = {1'b0, r_empty} + {1'b0, w_s_col};
      if (w_full)
         w_empty_n = '0;
      else if (r_empty < i_min_empty)
         w_empty_n = w_empty_sum[COL_W] ? '1 : w_empty_sum[COL_W-1:0];
      else if (w_type != 4'd0)
         w_empty_n = '0;
      else if (r_empty > L_NEQ)
         w_empty_n = r_empty - L_NEQ;
      else
         w_empty_n = '0;
   end

   // A slot that scrolls off this tick was enabled pre-tick, so it is never the load target.
   always_comb begin
      w_cnt_n = 4'd0;
      for (int i = 0; i < SLOTS; i++) begin
         w_en_n[i]   = 1'b0;
         w_type_n[i] = 4'd0;
         w_col_n[i]  = '0;
         if (w_load && (w_free_idx == IDX_W'(i))) begin
            w_en_n[i]   = 1'b1;
            w_type_n[i] = w_type;
            w_col_n[i]  = L_SPAWN_COL;
         end else if (r_en[i] && !(r_col[i] < w_s_col)) begin
            w_en_n[i]   = 1'b1;
            w_type_n[i] = r_type[i];
            w_col_n[i]  = r_col[i] - w_s_col;
         end
         w_cnt_n = w_cnt_n + {3'b000, w_en_n[i]};
      end
   end

   always_comb begin
      logic c;
      w_px_sum    = r_px + PX_W'(w_spd);
      w_score_inc = r_score;
      c           = 1'b1;
      for (int d = 0; d < SCORE_DIGITS; d++) begin
         if (c) begin
            if (r_score[d*4 +: 4] == 4'd9) begin
               w_score_inc[d*4 +: 4] = 4'd0;
            end else begin
               w_score_inc[d*4 +: 4] = r_score[d*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr   <= SEED;
         r_empty  <= '0;
         r_px     <= '0;
         r_score  <= '0;
         r_spawn  <= 1'b0;
         r_active <= 4'd0;
         for (int i = 0; i < SLOTS; i++) begin
            r_en[i]   <= 1'b0;
            r_type[i] <= 4'd0;
            r_col[i]  <= '0;
         end
      end else begin
         r_lfsr  <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         r_spawn <= w_load;
         if (w_adv) begin
            for (int i = 0; i < SLOTS; i++) begin
               r_en[i]   <= w_en_n[i];
               r_type[i] <= w_type_n[i];
               r_col[i]  <= w_col_n[i];
            end
            r_active <= w_cnt_n;
            r_empty  <= w_empty_n;
            if (w_px_sum >= L_PPP) begin
               r_px <= w_px_sum - L_PPP;
               if (r_score != L_SCORE_MAX)
                  r_score <= w_score_inc;
            end else begin
               r_px <= w_px_sum;
            end
         end
      end
   end

   for (genvar g = 0; g < SLOTS; g++) begin : g_pack
      assign o_obstacles[g*SW +: SW] = {r_en[g], r_type[g], r_col[g]};
   end

   assign o_spawn      = r_spawn;
   assign o_active_cnt = r_active;
   assign o_score      = r_score;

`ifdef OBST_HISCORE_EN
   logic [4*SCORE_DIGITS-1:0] r_hiscore;
   logic                      r_over_d;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hiscore <= '0;
         r_over_d  <= 1'b0;
      end else begin
         r_over_d <= i_over;
         if (i_over && !r_over_d && (r_score > r_hiscore))
            r_hiscore <= r_score;
      end
   end

   assign o_hiscore = r_hiscore;
`else
   assign o_hiscore = '0;
`endif

endmodule

// File: tb/tb_obstacle_spawner.sv
`timescale 1ns/1ps
// Directed bench for obstacle_spawner: vector table for scroll/spawn sequences plus hand-written reset, score and over cases.
module tb_obstacle_spawner;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        over = 1'b0;
   logic [2:0]  speed = 3'd1;
   logic [9:0]  min_empty = 10'd0;
   logic [44:0] obstacles;
   logic        spawn;
   logic [3:0]  active_cnt;
   logic [15:0] score;
   logic [15:0] hiscore;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   obstacle_spawner dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_over(over), .i_speed(speed),
      .i_min_empty(min_empty), .o_obstacles(obstacles), .o_spawn(spawn),
      .o_active_cnt(active_cnt), .o_score(score), .o_hiscore(hiscore)
   );

   // Reference LFSR: lets the bench know which draw the next tick edge will see.
   logic [15:0] m_lfsr;
   always @(posedge clk or posedge rst) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic logic [3:0] draw(input logic [7:0] r);
      int g;
      if (r < 8'd96) return 4'd0;
      if (r < 8'd192) begin
         g = (int'(r) - 96) / 16;
         case (g)
            0: return 4'd1;
            1: return 4'd2;
            2: return 4'd3;
            3: return 4'd5;
            4: return 4'd6;
            default: return 4'd7;
         endcase
      end
      if (r < 8'd208) return 4'd9;
      if (r < 8'd224) return 4'd10;
      if (r < 8'd240) return 4'd11;
      return 4'd0;
   endfunction

   function automatic logic [14:0] slot(input int i);
      return obstacles[i*15 +: 15];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick1();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick1();
   endtask

   task automatic wait_nz(output logic [3:0] t);
      int n;
      n = 0;
      while (draw(m_lfsr[7:0]) == 4'd0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_nz: no obstacle draw within 1000 cycles");
      end
      t = draw(m_lfsr[7:0]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      tick = 1'b0;
      over = 1'b0;
      rst  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      int         n;
      logic [2:0] spd;
      logic [9:0] min_e;
      bit         nz;
      bit         en0;
      logic [9:0] col0;
      logic [3:0] act;
      bit         spn;
      int         tslot;
   } vec_t;

   vec_t tbl [13];
   logic [15:0] exp_hi;

   initial begin
      logic [3:0] t;

      tbl[0]  = '{99, 3'd7, 10'd1023, 1'b0, 1'b1, 10'd6,   4'd1, 1'b0, -1};
      tbl[1]  = '{1,  3'd3, 10'd1023, 1'b0, 1'b1, 10'd3,   4'd1, 1'b0, -1};
      tbl[2]  = '{1,  3'd4, 10'd1023, 1'b0, 1'b0, 10'd0,   4'd0, 1'b0, -1};
      tbl[3]  = '{1,  3'd4, 10'd0,    1'b1, 1'b1, 10'd700, 4'd1, 1'b1,  0};
      tbl[4]  = '{1,  3'd4, 10'd1023, 1'b0, 1'b1, 10'd696, 4'd1, 1'b0, -1};
      tbl[5]  = '{1,  3'd0, 10'd1023, 1'b0, 1'b1, 10'd695, 4'd1, 1'b0, -1};
      tbl[6]  = '{1,  3'd1, 10'd0,    1'b1, 1'b1, 10'd694, 4'd2, 1'b1,  1};
      tbl[7]  = '{1,  3'd1, 10'd0,    1'b1, 1'b1, 10'd693, 4'd3, 1'b1,  2};
      tbl[8]  = '{1,  3'd1, 10'd0,    1'b1, 1'b1, 10'd692, 4'd3, 1'b0, -1};
      tbl[9]  = '{98, 3'd7, 10'd0,    1'b0, 1'b1, 10'd6,   4'd3, 1'b0, -1};
      tbl[10] = '{1,  3'd7, 10'd0,    1'b0, 1'b0, 10'd0,   4'd2, 1'b0, -1};
      tbl[11] = '{1,  3'd1, 10'd1,    1'b1, 1'b0, 10'd0,   4'd2, 1'b0, -1};
      tbl[12] = '{1,  3'd1, 10'd1,    1'b1, 1'b1, 10'd700, 4'd3, 1'b1,  0};
`ifdef OBST_HISCORE_EN
      exp_hi = 16'h0042;
`else
      exp_hi = 16'h0000;
`endif

      // Asynchronous reset, then a tick held during reset
      #1 rst = 1'b1;
      #1;
      chk("rst obstacles", 32'(obstacles[31:0]), 32'd0);
      chk("rst obstacles hi", 32'(obstacles[44:32]), 32'd0);
      chk("rst spawn", 32'(spawn), 32'd0);
      chk("rst active", 32'(active_cnt), 32'd0);
      chk("rst score", 32'(score), 32'd0);
      chk("rst hiscore", 32'(hiscore), 32'd0);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      chk("tick in rst active", 32'(active_cnt), 32'd0);
      chk("tick in rst slot0", 32'(slot(0)), 32'd0);
      rst = 1'b0;
      speed = 3'd1;
      min_empty = 10'd0;
      @(negedge clk);
      tick = 1'b0;
      // SEED low byte 0xE1 = 225 draws BirdH
      chk("seed draw slot0", 32'(slot(0)), 32'({1'b1, 4'd11, 10'd700}));
      chk("seed spawn", 32'(spawn), 32'd1);
      chk("seed active", 32'(active_cnt), 32'd1);
      @(negedge clk);
      chk("spawn pulse width", 32'(spawn), 32'd0);

      // Spawn spacing with min_empty=10, speed=1
      do_reset();
      min_empty = 10'd10;
      speed = 3'd1;
      for (int k = 1; k <= 10; k++) begin
         tick1();
         chk($sformatf("spacing tick%0d spawn", k), 32'(spawn), 32'd0);
      end
      wait_nz(t);
      tick1();
      chk("spacing tick11 spawn", 32'(spawn), 32'd1);
      chk("spacing tick11 slot0", 32'(slot(0)), 32'({1'b1, t, 10'd700}));
      tick1();
      chk("spacing tick12 col", 32'(slot(0)), 32'({1'b1, t, 10'd699}));
      chk("spacing tick12 spawn", 32'(spawn), 32'd0);

      // Scroll / spawn / full-slot vectors
      for (int v = 0; v < 13; v++) begin
         speed = tbl[v].spd;
         min_empty = tbl[v].min_e;
         for (int k = 0; k < tbl[v].n; k++) begin
            if (tbl[v].nz) wait_nz(t);
            tick1();
         end
         chk($sformatf("vec%0d en0", v), 32'(slot(0) >> 14), 32'(tbl[v].en0));
         chk($sformatf("vec%0d col0", v), 32'(slot(0) & 15'h3FF), 32'(tbl[v].col0));
         chk($sformatf("vec%0d active", v), 32'(active_cnt), 32'(tbl[v].act));
         chk($sformatf("vec%0d spawn", v), 32'(spawn), 32'(tbl[v].spn));
         if (!tbl[v].en0)
            chk($sformatf("vec%0d slot0 zero", v), 32'(slot(0)), 32'd0);
         if (tbl[v].tslot >= 0)
            chk($sformatf("vec%0d type", v), 32'((slot(tbl[v].tslot) >> 10) & 15'hF), 32'(t));
      end
      chk("full slot1 col", 32'(slot(1) & 15'h43FF), 32'h4003);
      chk("full slot2 col", 32'(slot(2) & 15'h43FF), 32'h4004);

      // Reset in mid-cycle during play
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst obstacles", 32'(obstacles[31:0]), 32'd0);
      chk("midrst active", 32'(active_cnt), 32'd0);
      chk("midrst score", 32'(score), 32'd0);
      chk("midrst hiscore", 32'(hiscore), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      speed = 3'd1;
      min_empty = 10'd0;
      tick1();
      chk("midrst seed draw", 32'(slot(0)), 32'({1'b1, 4'd11, 10'd700}));

      // Score: BCD carry and saturation
      do_reset();
      speed = 3'd7;
      min_empty = 10'd1023;
      ticks(2997);
      chk("score 0999", 32'(score), 32'h0999);
      speed = 3'd4;
      ticks(5);
      chk("score 5 ticks", 32'(score), 32'h0999);
      tick1();
      chk("score carry 1000", 32'(score), 32'h1000);
      ticks(4);
      chk("score px residue", 32'(score), 32'h1000);
      tick1();
      chk("score 1001", 32'(score), 32'h1001);
      speed = 3'd7;
      ticks(26994);
      chk("score 9999", 32'(score), 32'h9999);
      ticks(6);
      chk("score saturate", 32'(score), 32'h9999);

      // Over freezes game state; hiscore captures on its rising edge
      do_reset();
      speed = 3'd7;
      min_empty = 10'd1023;
      ticks(126);
      chk("over score 42", 32'(score), 32'h0042);
      chk("over pre active", 32'(active_cnt), 32'd0);
      chk("over pre hiscore", 32'(hiscore), 32'd0);
      min_empty = 10'd0;
      speed = 3'd1;
      wait_nz(t);
      tick1();
      chk("over pre spawn", 32'(slot(0)), 32'({1'b1, t, 10'd700}));
      over = 1'b1;
      @(negedge clk);
      chk("over hiscore", 32'(hiscore), 32'(exp_hi));
      speed = 3'd7;
      ticks(5);
      chk("over hold slot0", 32'(slot(0)), 32'({1'b1, t, 10'd700}));
      chk("over hold score", 32'(score), 32'h0042);
      chk("over hold active", 32'(active_cnt), 32'd1);
      chk("over no spawn", 32'(spawn), 32'd0);
      over = 1'b0;
      min_empty = 10'd1023;
      speed = 3'd1;
      tick1();
      chk("resume slot0", 32'(slot(0)), 32'({1'b1, t, 10'd699}));
      chk("resume score", 32'(score), 32'h0042);
      chk("resume hiscore", 32'(hiscore), 32'(exp_hi));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: test did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Parametrised obstacle generator and scroller for the Dino game. It holds `SLOTS` obstacle slots, spawns random obstacle types at the right screen edge once enough empty pixels have scrolled past, and moves every active obstacle left by a programmable speed on each game tick. It also keeps the BCD running score. It sits between the game-state FSM, which supplies `tick`, `over` and `speed`, and the renderer and collision logic, which consume `obstacles`.

## Interface
Parameters:
- `SLOTS`, 3: number of obstacle slots (2..8).
- `COL_W`, 10: column width in bits.
- `SPAWN_COL`, 700: column loaded into a newly spawned slot.
- `NOTHING_EQUI`, 53: empty-pixel credit consumed by a "Nothing" draw.
- `PX_PER_POINT`, 21: scrolled pixels per score point.
- `SCORE_DIGITS`, 4: BCD score digits.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: one-`clk` game-step strobe; all game state advances only on it.
- `over`, in, 1: game over; freezes all game state.
- `speed`, in, 3: pixels moved per tick; 0 is treated as 1.
- `min_empty`, in, `COL_W`: minimum empty pixels between spawns.
- `obstacles`, out, `SLOTS*(5+COL_W)`: packed slots, slot i at `[i*(5+COL_W) +: 5+COL_W]`. Each slot is `{en, type[3:0], col[COL_W-1:0]}`.
- `spawn`, out, 1: one-cycle pulse on the tick that loads a slot.
- `active_cnt`, out, 4: number of enabled slots.
- `score`, out, `4*SCORE_DIGITS`: BCD score.
- `hiscore`, out, `4*SCORE_DIGITS`: BCD best score (see Configuration).

## Operation
LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Shifts every `clk`, including while `over`.

Type draw uses `r = lfsr[7:0]`:
- `r < 96`: Nothing (0).
- `96..191`: cactus; group `(r-96)>>4` (0..5) maps to codes 1, 2, 3, 5, 6, 7.
- `192..207`: BirdL (9).
- `208..223`: BirdM (10).
- `224..239`: BirdH (11).
- `≥ 240`: Nothing.

The following apply on a clock edge with `tick=1` and `over=0`. `s` denotes the effective speed. All decisions use pre-tick register values.

Move, for each enabled slot not being loaded this tick:
- If `col < s`: slot becomes all-zero.
- Otherwise: `col -= s`.
- Disabled slots stay all-zero.

Spawn, with `empty_cnt` a `COL_W`-bit counter:
- If all slots are enabled: `empty_cnt <= 0`.
- Else if `empty_cnt < min_empty`: `empty_cnt += s`, saturating at all-ones.
- Else if the drawn type ≠ 0: the lowest-index disabled slot is loaded with `{1, type, SPAWN_COL}`, `empty_cnt <= 0`, and `spawn` pulses.
- Else: `empty_cnt <= (empty_cnt > NOTHING_EQUI) ? empty_cnt - NOTHING_EQUI : 0`.
- Moves of the other slots proceed on the same tick as a spawn. A spawn never freezes scrolling.
- A slot freed on this tick is not eligible for loading until the next tick.

Score:
- `px_cnt += s` each tick.
- When the sum reaches `PX_PER_POINT` or more: subtract `PX_PER_POINT` and add 1 to `score` in BCD.
- Increments carry across digits.
- Score saturates at all-9s; `px_cnt` continues to count.

Other rules:
- `active_cnt` is registered and reflects the post-edge slot state.
- `over=1` holds `obstacles`, `score`, `empty_cnt` and `px_cnt`; `tick` is ignored.
- `tick` while `rst` is high is ignored.

## Timing
- `rst` asserts asynchronously and forces every output to 0, along with `empty_cnt` and `px_cnt`. The LFSR is forced to `SEED`.
- Release of `rst` is synchronous to the next `clk` edge.
- All outputs are registered. A tick's effect is visible the cycle after the `tick` edge.
- `spawn` is high for exactly that one cycle.
- Reset during play clears all slots immediately, with no drain.
- Back-to-back `tick` cycles are legal; each is processed fully.

## Configuration
Macro `OBST_HISCORE_EN`:
- Defined: `hiscore` is a register cleared by `rst`. On the first `clk` with `over=1` after a cycle with `over=0`, it loads `score` if `score > hiscore`. BCD is compared as unsigned binary.
- Undefined: `hiscore` is constant 0 and no register is inferred.

## Test plan
1. Reset check: assert `rst` mid-cycle. Required: outputs are 0 asynchronously, before the next edge. After release, the first draw uses `SEED`.
2. Spawn spacing: `min_empty=10`, `speed=1`, force non-Nothing draws via a `SEED` sweep. Required: the first spawn occurs on tick 11 with col 700. After the next tick the slot shows col 699.
3. Speed 4: with slot col=3, one tick. Required: slot clears and `active_cnt` decrements. With col=700 the result is 696. `speed=0` moves by 1.
4. Full slots: all 3 enabled and `empty_cnt` at threshold. Required: no spawn and `empty_cnt=0`. After slot 0 exits, the next eligible spawn loads slot 0.
5. Score: `PX_PER_POINT=21`, `speed=4`, score 0x0999. Required: after 6 ticks score becomes 0x1000 with `px_cnt=3`. Starting from 0x9999, score remains 0x9999.
6. Over and hiscore (with `OBST_HISCORE_EN`): score 0x0042, raise `over`. Required: hiscore becomes 0x0042 and ticks change nothing. Without the macro, hiscore stays 0.
